// File: rtl/hsc_ddr2_port_arbiter.sv
// Round-robin arbiter sharing one DDR2 controller local interface between NUM_PORTS burst ports.
// Define HSC_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module hsc_ddr2_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int AW        = 24,
  parameter int DW        = 32,
  parameter int SW        = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    local_init_done,
  input  logic [NUM_PORTS-1:0]    port_req,
  input  logic [NUM_PORTS-1:0]    port_we,
  input  logic [NUM_PORTS*AW-1:0] port_addr,
  input  logic [NUM_PORTS*SW-1:0] port_size,
  input  logic [NUM_PORTS*DW-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]    port_grant,
  output logic [NUM_PORTS-1:0]    port_wr_ack,
  output logic [NUM_PORTS-1:0]    port_rd_valid,
  output logic [DW-1:0]           port_rdata,
  output logic [NUM_PORTS-1:0]    port_done,
  output logic [AW-1:0]           local_address,
  output logic [SW-1:0]           local_size,
  output logic                    local_write_req,
  output logic                    local_read_req,
  output logic [DW-1:0]           local_wdata,
  input  logic                    local_ready,
  input  logic [DW-1:0]           local_rdata,
  input  logic                    local_rdata_valid,
  output logic                    arb_err
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_CMD,
    RD_DATA,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] pick;
  logic          pick_valid;
  logic [SW-1:0] beat_cnt;
  logic          last_beat;
  logic [SW-1:0] pick_size;

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    idx        = 0;
    cand       = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = PW'(idx);
      if (port_req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  assign pick_size = port_size[pick*SW +: SW];
  assign last_beat = (beat_cnt == (local_size - SW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      gidx            <= '0;
      port_grant      <= '0;
      port_done       <= '0;
      local_address   <= '0;
      local_size      <= '0;
      local_write_req <= 1'b0;
      local_read_req  <= 1'b0;
      beat_cnt        <= '0;
      arb_err         <= 1'b0;
    end else begin
      port_done <= '0;
      if (local_rdata_valid && (state != RD_DATA)) arb_err <= 1'b1;
      case (state)
        IDLE: begin
          if (local_init_done && pick_valid) begin
            gidx          <= pick;
            port_grant    <= NUM_PORTS'(1) << pick;
            local_address <= port_addr[pick*AW +: AW];
            local_size    <= (pick_size == '0) ? SW'(1) : pick_size;
            beat_cnt      <= '0;
            if (port_we[pick]) begin
              state           <= WR;
              local_write_req <= 1'b1;
            end else begin
              state          <= RD_CMD;
              local_read_req <= 1'b1;
            end
          end
        end
        WR: begin
          if (local_ready) begin
            if (last_beat) begin
              state           <= DONE;
              local_write_req <= 1'b0;
              port_done       <= port_grant;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RD_CMD: begin
          if (local_ready) begin
            state          <= RD_DATA;
            local_read_req <= 1'b0;
          end
        end
        RD_DATA: begin
          if (local_rdata_valid) begin
            if (last_beat) begin
              state     <= DONE;
              port_done <= port_grant;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          port_grant    <= '0;
          local_address <= '0;
          local_size    <= '0;
          beat_cnt      <= '0;
`ifdef HSC_ARB_FIXED_PRIO_EN
          rr_ptr        <= '0;
`else
          rr_ptr        <= (gidx == PW'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat strobes are combinational so the port sees the handshake in the cycle it happens.
  assign port_wr_ack   = ((state == WR) && local_ready) ? port_grant : '0;
  assign port_rd_valid = ((state == RD_DATA) && local_rdata_valid) ? port_grant : '0;
  assign port_rdata    = (state == RD_DATA) ? local_rdata : '0;

  always_comb begin
    local_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_grant[i]) local_wdata = local_wdata | port_wdata[i*DW +: DW];
    end
  end

endmodule

// File: tb/tb_hsc_ddr2_port_arbiter.sv
// Scoreboard bench for hsc_ddr2_port_arbiter: expected grant/beat/done events are queued at
// stimulus time and a negedge monitor pops and compares them as the DUT produces them.
module tb_hsc_ddr2_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = 7;

  localparam int K_GRANT = 0;
  localparam int K_WR    = 1;
  localparam int K_RD    = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int          kind;
    int          port;
    logic [31:0] data;
    logic [23:0] addr;
    logic [6:0]  size;
    bit          we;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            local_init_done;
  logic [N-1:0]    port_req, port_we;
  logic [N*AW-1:0] port_addr;
  logic [N*SW-1:0] port_size;
  logic [N*DW-1:0] port_wdata;
  logic [N-1:0]    port_grant, port_wr_ack, port_rd_valid, port_done;
  logic [DW-1:0]   port_rdata;
  logic [AW-1:0]   local_address;
  logic [SW-1:0]   local_size;
  logic            local_write_req, local_read_req;
  logic [DW-1:0]   local_wdata;
  logic            local_ready;
  logic [DW-1:0]   local_rdata;
  logic            local_rdata_valid;
  logic            arb_err;

  ev_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   grants_seen = 0;
  logic [N-1:0] prev_grant = '0;

  hsc_ddr2_port_arbiter #(.NUM_PORTS(N), .AW(AW), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .local_init_done(local_init_done),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_size(port_size), .port_wdata(port_wdata),
    .port_grant(port_grant), .port_wr_ack(port_wr_ack), .port_rd_valid(port_rd_valid),
    .port_rdata(port_rdata), .port_done(port_done),
    .local_address(local_address), .local_size(local_size),
    .local_write_req(local_write_req), .local_read_req(local_read_req),
    .local_wdata(local_wdata), .local_ready(local_ready),
    .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_GRANT: return "grant";
      K_WR:    return "wr_ack";
      K_RD:    return "rd_valid";
      default: return "done";
    endcase
  endfunction

  function automatic logic [31:0] rd_pattern(input int p, input int b);
    return 32'hD000_0000 | 32'(p << 8) | 32'(b);
  endfunction

  task automatic pop_expect(input int kind, output ev_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e  = '{default: 0};
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_%s: got unexpected %s event, required nothing pending", kname(kind), kname(kind));
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("[TB] FAIL sb_order: got %s event, required %s event", kname(kind), kname(e.kind));
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: compares every grant edge, beat strobe and done pulse against the queue.
  initial begin
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_grant = '0;
      end else begin
        if ((port_grant != '0) && (prev_grant == '0)) begin
          grants_seen++;
          pop_expect(K_GRANT, e, ok);
          if (ok) begin
            check_output("grant_vec", 64'(port_grant), 64'(4'b0001 << e.port));
            check_output("grant_addr", 64'(local_address), 64'(e.addr));
            check_output("grant_size", 64'(local_size), 64'(e.size));
            check_output("grant_cmd", 64'({local_write_req, local_read_req}), e.we ? 64'd2 : 64'd1);
          end
        end
        if (port_wr_ack != '0) begin
          pop_expect(K_WR, e, ok);
          if (ok) begin
            check_output("wr_ack_vec", 64'(port_wr_ack), 64'(4'b0001 << e.port));
            check_output("wr_data", 64'(local_wdata), 64'(e.data));
          end
        end
        if (port_rd_valid != '0) begin
          pop_expect(K_RD, e, ok);
          if (ok) begin
            check_output("rd_valid_vec", 64'(port_rd_valid), 64'(4'b0001 << e.port));
            check_output("rd_data", 64'(port_rdata), 64'(e.data));
          end
        end
        if (port_done != '0) begin
          pop_expect(K_DONE, e, ok);
          if (ok) check_output("done_vec", 64'(port_done), 64'(4'b0001 << e.port));
        end
        prev_grant = port_grant;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n             = 1'b0;
    port_req          = '0;
    port_we           = '0;
    port_addr         = '0;
    port_size         = '0;
    port_wdata        = '0;
    local_init_done   = 1'b1;
    local_ready       = 1'b0;
    local_rdata       = '0;
    local_rdata_valid = 1'b0;
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic apply_stimulus(input int p, input bit we, input logic [23:0] addr,
                                input logic [6:0] size, input logic [31:0] wdata);
    port_we[p]             = we;
    port_addr[p*AW +: AW]  = addr;
    port_size[p*SW +: SW]  = size;
    port_wdata[p*DW +: DW] = wdata;
  endtask

  task automatic expect_burst(input int p, input bit we, input logic [23:0] addr,
                              input logic [6:0] size, input logic [31:0] wdata);
    int  n;
    ev_t e;
    n = (size == 7'd0) ? 1 : int'(size);
    e = '{kind: K_GRANT, port: p, data: 32'd0, addr: addr, size: 7'(n), we: we};
    sb_q.push_back(e);
    for (int b = 0; b < n; b++) begin
      e = '{kind: (we ? K_WR : K_RD), port: p, data: (we ? wdata : rd_pattern(p, b)),
            addr: 24'd0, size: 7'd0, we: we};
      sb_q.push_back(e);
    end
    e = '{kind: K_DONE, port: p, data: 32'd0, addr: 24'd0, size: 7'd0, we: we};
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      step();
    end
    check_output(name, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int g0;
    int order[5];

    reset_dut();
    check_output("rst_ctrl", 64'({port_grant, port_wr_ack, port_rd_valid, port_done,
                                  local_write_req, local_read_req, arb_err}), 64'd0);
    check_output("rst_local", 64'({local_address, local_size}), 64'd0);

    // Single write burst from port 0 with the controller always ready.
    apply_stimulus(0, 1'b1, 24'h000040, 7'd4, 32'hCAFE_0001);
    expect_burst(0, 1'b1, 24'h000040, 7'd4, 32'hCAFE_0001);
    local_ready = 1'b1;
    port_req    = 4'b0001;
    step();
    check_output("t1_grant", 64'(port_grant), 64'h1);
    port_req = '0;
    n = 0;
    while (local_write_req && n < 20) begin
      n++;
      step();
    end
    check_output("t1_wreq_cycles", 64'(n), 64'd4);
    check_output("t1_done", 64'(port_done), 64'h1);
    step();
    check_output("t1_done_pulse", 64'(port_done), 64'h0);
    wait_drain("t1_drain");
    check_output("t1_idle_local", 64'({local_address, local_size}), 64'd0);
    check_output("t1_idle_wdata", 64'(local_wdata), 64'd0);

    // Port 1 read, command held off by three not-ready cycles.
    local_ready = 1'b0;
    apply_stimulus(1, 1'b0, 24'h000100, 7'd8, 32'd0);
    expect_burst(1, 1'b0, 24'h000100, 7'd8, 32'd0);
    port_req = 4'b0010;
    step();
    port_req = '0;
    check_output("t2_addr", 64'(local_address), 64'h100);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!local_read_req) break;
      n++;
      local_ready = (n >= 4);
      step();
    end
    local_ready = 1'b0;
    check_output("t2_rreq_cycles", 64'(n), 64'd4);
    for (int b = 0; b < 8; b++) begin
      if (b == 4) begin
        local_rdata_valid = 1'b0;
        step();
      end
      local_rdata       = rd_pattern(1, b);
      local_rdata_valid = 1'b1;
      step();
    end
    local_rdata_valid = 1'b0;
    local_rdata       = '0;
    check_output("t2_done", 64'(port_done), 64'h2);
    wait_drain("t2_drain");
    check_output("t2_arb_err", 64'(arb_err), 64'd0);

    // Port 3 write with local_ready toggling 1,0,1,0...
    apply_stimulus(3, 1'b1, 24'h003300, 7'd4, 32'h3333_AAAA);
    expect_burst(3, 1'b1, 24'h003300, 7'd4, 32'h3333_AAAA);
    port_req = 4'b1000;
    step();
    port_req = '0;
    n = 0;
    while (local_write_req && n < 20) begin
      n++;
      local_ready = n[0];
      step();
    end
    local_ready = 1'b1;
    check_output("t4_wr_cycles", 64'(n), 64'd7);
    check_output("t4_done", 64'(port_done), 64'h8);
    wait_drain("t4_drain");

    // Size 0 is carried as a single beat.
    apply_stimulus(2, 1'b1, 24'hABCDEF, 7'd0, 32'h1234_5678);
    expect_burst(2, 1'b1, 24'hABCDEF, 7'd0, 32'h1234_5678);
    port_req = 4'b0100;
    step();
    port_req = '0;
    wait_drain("t7_drain");

    // All ports requesting continuously.
    reset_dut();
    local_ready = 1'b1;
`ifdef HSC_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    for (int p = 0; p < N; p++)
      apply_stimulus(p, 1'b1, 24'(p) << 12, 7'd2, 32'hB0B0_0000 | 32'(p));
    for (int i = 0; i < 5; i++)
      expect_burst(order[i], 1'b1, 24'(order[i]) << 12, 7'd2, 32'hB0B0_0000 | 32'(order[i]));
    g0 = grants_seen;
    port_req = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      if (grants_seen >= g0 + 5) break;
      step();
    end
    port_req = '0;
    check_output("t3_grants", 64'(grants_seen - g0), 64'd5);
    wait_drain("t3_drain");

    // Read data arriving while idle is dropped and flags a sticky error.
    check_output("t5_err_pre", 64'(arb_err), 64'd0);
    local_rdata       = 32'h5555_5555;
    local_rdata_valid = 1'b1;
    #1;
    check_output("t5_no_rd_valid", 64'(port_rd_valid), 64'd0);
    step();
    local_rdata_valid = 1'b0;
    local_rdata       = '0;
    check_output("t5_err_set", 64'(arb_err), 64'd1);
    repeat (3) step();
    check_output("t5_err_sticky", 64'(arb_err), 64'd1);
    reset_dut();
    check_output("t5_err_cleared", 64'(arb_err), 64'd0);

    // No grants before calibration, then reset in the middle of a read data phase.
    local_init_done = 1'b0;
    for (int p = 0; p < N; p++)
      apply_stimulus(p, 1'b0, 24'h000600 + 24'(p), 7'd6, 32'hEEEE_0000 | 32'(p));
    port_req = 4'b1111;
    repeat (5) step();
    check_output("t6_no_grant", 64'({port_grant, local_read_req, local_write_req}), 64'd0);
    expect_burst(0, 1'b0, 24'h000600, 7'd6, 32'd0);
    local_init_done = 1'b1;
    step();
    check_output("t6_grant", 64'(port_grant), 64'h1);
    port_req    = '0;
    local_ready = 1'b1;
    step();
    local_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      local_rdata       = rd_pattern(0, b);
      local_rdata_valid = 1'b1;
      step();
    end
    local_rdata_valid = 1'b0;
    local_rdata       = '0;
    #2 rst_n = 1'b0;
    #1;
    check_output("t6_rst_ctrl", 64'({port_grant, port_wr_ack, port_rd_valid, port_done,
                                     local_write_req, local_read_req, arb_err}), 64'd0);
    check_output("t6_rst_local", 64'({local_address, local_size}), 64'd0);
    check_output("t6_rst_data", {port_rdata, local_wdata}, 64'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    apply_stimulus(1, 1'b1, 24'h000777, 7'd1, 32'h0BAD_F00D);
    expect_burst(1, 1'b1, 24'h000777, 7'd1, 32'h0BAD_F00D);
    local_ready = 1'b1;
    port_req    = 4'b0010;
    step();
    check_output("t6_regrant", 64'(port_grant), 64'h2);
    port_req = '0;
    wait_drain("t6_drain");

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
